mem_port_arbiter: RTL

- Sequences one shared single-port unified instruction/data memory between the pipeline fetch stage (IF) and the memory stage (DM).
- Arbitrates between the two, holds each transaction until the memory reports ready, and returns the read data.
- Drives stall_f/stall_m into the hazard unit so the pipeline freezes while its access is pending.
- Includes anti-starvation for fetch and a memory-timeout watchdog.

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port unified memory between fetch (IF) and the memory stage (DM),
// with fetch anti-starvation and a mem_ready watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_DM_STREAK = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_f,
  output logic              stall_m,
  output logic              err_timeout
);

  localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam int unsigned WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic                err_q, err_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                if_cand, dm_cand, finish, timed_out;

  // A requester acked this cycle is still holding its old request; ignore it.
  assign if_cand   = if_req & ~if_ack_q;
  assign dm_cand   = dm_req & ~dm_ack_q;
  assign timed_out = ~mem_ready & (wait_cnt_q == WAIT_W'(TIMEOUT - 1));
  assign finish    = mem_ready | timed_out;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = err_q;
    streak_d    = streak_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (dm_cand && (!if_cand || streak_q < STREAK_W'(MAX_DM_STREAK))) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          wait_cnt_d  = '0;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q < STREAK_W'(MAX_DM_STREAK)) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (if_cand) begin
          state_d    = BUSY_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          wait_cnt_d = '0;
          streak_d   = '0;
        end
      end

      BUSY_IF, BUSY_DM: begin
        if (finish) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (timed_out) begin
            err_d = 1'b1;
          end
          // A watchdog abort returns zero data to the owner.
          if (state_q == BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            dm_ack_d = 1'b1;
            if (timed_out || !mem_we_q) begin
              dm_rdata_d = mem_ready ? mem_rdata : '0;
            end
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      streak_q    <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
      streak_q    <= streak_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign if_ack      = if_ack_q;
  assign dm_ack      = dm_ack_q;
  assign err_timeout = err_q;
  assign stall_f     = if_req & ~if_ack_q;
  assign stall_m     = dm_req & ~dm_ack_q;

endmodule
